// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-field encoding and the {N,Z,C,V} flag layout.
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether a condition field passes
// against a flag value, and flags the reserved encoding.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       pass,
    output logic       illegal
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass    = 1'b0;
        illegal = 1'b0;
        case (cond_t'(cond))
            EQ: pass = z;
            NE: pass = !z;
            CS: pass = c;
            CC: pass = !c;
            MI: pass = n;
            PL: pass = !n;
            VS: pass = v;
            VC: pass = !v;
            HI: pass = c && !z;
            LS: pass = !c || z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = !z && (n == v);
            LE: pass = z || (n != v);
            AL: pass = 1'b1;
            NV: illegal = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: architectural flag register, condition gating of
// execute-stage controls, and the E/M pipeline registers for those controls.
module cond_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic       valid_e,
    input  logic [3:0] cond_e,
    input  logic [1:0] flag_w_e,
    input  logic [3:0] alu_flags_e,
    input  logic       pcs_e,
    input  logic       reg_write_e,
    input  logic       mem_write_e,
    output logic       cond_ex_e,
    output logic       pcsrc_m,
    output logic       reg_write_m,
    output logic       mem_write_m,
    output logic       valid_m,
    output logic       cond_illegal_m,
    output logic [3:0] flags_o
);

    flags_t flags_q, flags_d;
    logic   valid_q, valid_d;
    logic   pcsrc_q, pcsrc_d;
    logic   reg_write_q, reg_write_d;
    logic   mem_write_q, mem_write_d;
    logic   illegal_q, illegal_d;

    logic   cond_pass;
    logic   cond_nv;
    logic   flag_upd;

    cond_check u_cond_check (
        .cond    (cond_e),
        .flags   (flags_q),
        .pass    (cond_pass),
        .illegal (cond_nv)
    );

    assign cond_ex_e = valid_e & cond_pass;
    // Flush takes priority over stall, and both block the flag write.
    assign flag_upd  = cond_ex_e & !stall_i & !flush_i;

    always_comb begin
        flags_d = flags_q;
        if (flag_upd && flag_w_e[1]) begin
            flags_d[FLAG_N] = alu_flags_e[FLAG_N];
            flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
        end
        if (flag_upd && flag_w_e[0]) begin
            flags_d[FLAG_C] = alu_flags_e[FLAG_C];
            flags_d[FLAG_V] = alu_flags_e[FLAG_V];
        end
    end

    always_comb begin
        valid_d     = valid_q;
        pcsrc_d     = pcsrc_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            pcsrc_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (!stall_i) begin
            valid_d     = valid_e;
            pcsrc_d     = pcs_e & cond_ex_e;
            reg_write_d = reg_write_e & cond_ex_e;
            mem_write_d = mem_write_e & cond_ex_e;
            illegal_d   = valid_e & cond_nv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            valid_q     <= 1'b0;
            pcsrc_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            valid_q     <= valid_d;
            pcsrc_q     <= pcsrc_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign flags_o        = flags_q;
    assign valid_m        = valid_q;
    assign pcsrc_m        = pcsrc_q;
    assign reg_write_m    = reg_write_q;
    assign mem_write_m    = mem_write_q;
    assign cond_illegal_m = illegal_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: per-cycle expected M-stage/flag state is
// queued at stimulus time and compared one cycle later.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall_i, flush_i, valid_e;
    logic [3:0] cond_e;
    logic [1:0] flag_w_e;
    logic [3:0] alu_flags_e;
    logic       pcs_e, reg_write_e, mem_write_e;
    logic       cond_ex_e, pcsrc_m, reg_write_m, mem_write_m, valid_m, cond_illegal_m;
    logic [3:0] flags_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] flags;
        logic       valid, pcs, rw, mw, ill;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    logic [3:0] m_flags;
    logic       m_valid, m_pcs, m_rw, m_mw, m_ill;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .valid_e        (valid_e),
        .cond_e         (cond_e),
        .flag_w_e       (flag_w_e),
        .alu_flags_e    (alu_flags_e),
        .pcs_e          (pcs_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .cond_ex_e      (cond_ex_e),
        .pcsrc_m        (pcsrc_m),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .valid_m        (valid_m),
        .cond_illegal_m (cond_illegal_m),
        .flags_o        (flags_o)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if      (c == 4'd0)  return z;
        else if (c == 4'd1)  return ~z;
        else if (c == 4'd2)  return cy;
        else if (c == 4'd3)  return ~cy;
        else if (c == 4'd4)  return n;
        else if (c == 4'd5)  return ~n;
        else if (c == 4'd6)  return v;
        else if (c == 4'd7)  return ~v;
        else if (c == 4'd8)  return cy & ~z;
        else if (c == 4'd9)  return ~cy | z;
        else if (c == 4'd10) return ~(n ^ v);
        else if (c == 4'd11) return n ^ v;
        else if (c == 4'd12) return ~z & ~(n ^ v);
        else if (c == 4'd13) return z | (n ^ v);
        else if (c == 4'd14) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_valid = 0; m_pcs = 0; m_rw = 0; m_mw = 0; m_ill = 0;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".flags_o"},     {4'b0, flags_o},       {4'b0, e.flags});
        chk({tag, ".valid_m"},     {7'b0, valid_m},       {7'b0, e.valid});
        chk({tag, ".pcsrc_m"},     {7'b0, pcsrc_m},       {7'b0, e.pcs});
        chk({tag, ".reg_write_m"}, {7'b0, reg_write_m},   {7'b0, e.rw});
        chk({tag, ".mem_write_m"}, {7'b0, mem_write_m},   {7'b0, e.mw});
        chk({tag, ".illegal_m"},   {7'b0, cond_illegal_m},{7'b0, e.ill});
    endtask

    // One execute-stage transaction: drive at negedge, check cond_ex_e, queue
    // the expected post-edge state, then pop and compare after the edge.
    task automatic step(input string tag, input logic v, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] af,
                        input logic p, input logic rw, input logic mw,
                        input logic st, input logic fl);
        logic pass;
        exp_t e;
        @(negedge clk);
        valid_e = v; cond_e = c; flag_w_e = fw; alu_flags_e = af;
        pcs_e = p; reg_write_e = rw; mem_write_e = mw; stall_i = st; flush_i = fl;
        #1;
        pass = v & ref_pass(c, m_flags);
        chk({tag, ".cond_ex_e"}, {7'b0, cond_ex_e}, {7'b0, pass});
        if (pass && !st && !fl) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
        end
        if (fl) begin
            m_valid = 0; m_pcs = 0; m_rw = 0; m_mw = 0; m_ill = 0;
        end else if (!st) begin
            m_valid = v; m_pcs = p & pass; m_rw = rw & pass; m_mw = mw & pass;
            m_ill = v & (c == 4'b1111);
        end
        e.flags = m_flags; e.valid = m_valid; e.pcs = m_pcs;
        e.rw = m_rw; e.mw = m_mw; e.ill = m_ill;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            check_state(tag, e);
        end
        $display("txn %s v=%0b cond=%h fw=%b af=%h st=%0b fl=%0b -> flags=%h valid_m=%0b",
                 tag, v, c, fw, af, st, fl, flags_o, valid_m);
    endtask

    task automatic set_flags(input logic [3:0] f);
        step("setf", 1, 4'he, 2'b11, f, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t z;
        rst_n = 0; stall_i = 0; flush_i = 0; valid_e = 0; cond_e = 0;
        flag_w_e = 0; alu_flags_e = 0; pcs_e = 0; reg_write_e = 0; mem_write_e = 0;
        model_reset();
        z.flags = 0; z.valid = 0; z.pcs = 0; z.rw = 0; z.mw = 0; z.ill = 0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", z);
        @(negedge clk);
        rst_n = 1;

        // flag set, then dependent EQ back-to-back
        step("al_set", 1, 4'he, 2'b11, 4'b0100, 0, 0, 0, 0, 0);
        step("eq_rw",  1, 4'h0, 2'b00, 4'b0000, 0, 1, 0, 0, 0);

        // failed GE does not write flags or controls
        set_flags(4'b1000);
        step("ge_fail", 1, 4'ha, 2'b11, 4'b0101, 1, 1, 1, 0, 0);

        // partial flag write: N,Z only
        set_flags(4'b0000);
        step("nz_only", 1, 4'he, 2'b10, 4'b1111, 0, 0, 0, 0, 0);

        // invalid instruction: no pass, no illegal
        step("inval", 0, 4'hf, 2'b11, 4'b0011, 1, 1, 1, 0, 0);

        // exhaustive cond x flags
        for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            for (int c = 0; c < 16; c++)
                step("sweep", 1, c[3:0], 2'b00, 4'b0000, c[0], 1, c[1], 0, 0);
        end

        // stall + flush with flag-setting AL
        set_flags(4'b0011);
        step("ld_m", 1, 4'he, 2'b00, 4'b0000, 1, 1, 1, 0, 0);
        step("st_fl", 1, 4'he, 2'b11, 4'b1100, 1, 1, 1, 1, 1);
        step("ld_m2", 1, 4'he, 2'b00, 4'b0000, 1, 0, 1, 0, 0);
        step("stall", 1, 4'he, 2'b11, 4'b1100, 0, 1, 0, 1, 0);
        step("stall2", 1, 4'hf, 2'b01, 4'b0101, 1, 1, 1, 1, 0);
        step("ill_ld", 1, 4'hf, 2'b11, 4'b1111, 1, 1, 1, 0, 0);
        step("ill_fl", 1, 4'he, 2'b00, 4'b0000, 0, 0, 0, 0, 1);

        // asynchronous reset mid-cycle
        set_flags(4'b1010);
        step("pre_rst", 1, 4'he, 2'b00, 4'b0000, 1, 1, 1, 0, 0);
        @(negedge clk);
        valid_e = 0; stall_i = 0; flush_i = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_state("async_rst", z);
        @(negedge clk);
        rst_n = 1;
        step("post_rst", 1, 4'h0, 2'b00, 4'b0000, 0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the pipelined CPU. It holds the architectural N,Z,C,V flag register fed by the ALU's 4-bit flag output and evaluates each execute-stage instruction's 4-bit condition field against the stored flags. It gates PCSrc/RegWrite/MemWrite accordingly and registers the gated controls into the memory stage. It sits between the execute-stage ALU and the E/M pipeline boundary.

## Interface
- No parameters; flag width fixed at 4, ordered {N,Z,C,V} (bit 3 = N).
- `clk` in 1: single system clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in 1: hold all state this cycle.
- `flush_i` in 1: kill the execute-stage instruction.
- `valid_e` in 1: execute-stage instruction valid.
- `cond_e` in 4: condition field.
- `flag_w_e` in 2: bit1 updates N,Z; bit0 updates C,V.
- `alu_flags_e` in 4: {N,Z,C,V} from the ALU for this instruction.
- `pcs_e`, `reg_write_e`, `mem_write_e` in 1 each: ungated controls.
- `cond_ex_e` out 1: combinational condition-pass for the current execute instruction.
- `pcsrc_m`, `reg_write_m`, `mem_write_m` out 1 each: registered gated controls.
- `valid_m` out 1: registered; instruction is live in M.
- `cond_illegal_m` out 1: registered; cond 4'b1111 was seen on a valid instruction.
- `flags_o` out 4: current flag register.

## Operation
- Condition codes, evaluated on `flags_o`:
  - EQ 0000 Z; NE 0001 !Z.
  - CS 0010 C; CC 0011 !C.
  - MI 0100 N; PL 0101 !N.
  - VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z.
  - GE 1010 N==V; LT 1011 N!=V.
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 always 1.
  - 1111: always 0, and sets `cond_illegal_m` on the next edge.
- `cond_ex_e` = `valid_e` & condition pass.
- Gated controls = ungated control & `cond_ex_e`.
- Flag update on a rising edge when `cond_ex_e` & !`stall_i` & !`flush_i`:
  - N,Z ← `alu_flags_e`[3:2] if `flag_w_e`[1].
  - C,V ← `alu_flags_e`[1:0] if `flag_w_e`[0].
  - Unselected bits hold their value.
- A failed-condition instruction never writes flags.
- M-stage registers on a rising edge:
  - `flush_i`=1: `valid_m`, all gated controls and `cond_illegal_m` clear to 0.
  - Else `stall_i`=1: all M registers hold.
  - Else: load `valid_e`, the gated controls, and the illegal indication.
- Simultaneous stall and flush: flush wins. M registers clear, flags hold.

## Timing
- Reset (async assert, released synchronously by the system): `flags_o`=4'b0000; `valid_m`, `pcsrc_m`, `reg_write_m`, `mem_write_m`, `cond_illegal_m` all 0.
- Reset mid-stream discards the M-stage instruction and flag state immediately.
- Condition evaluation is combinational from `flags_o`, with zero-cycle latency to `cond_ex_e`.
- M-stage outputs have 1-cycle latency.
- Flag write is visible to the instruction in E the following cycle. Back-to-back flag-set then conditional needs no stall.
- The flag source is the ALU output in the same cycle. The ALU's internal flag timing is absorbed upstream; this block samples `alu_flags_e` on the rising edge only.

## Structure
- Shared package `cpu_pkg`:
  - `cond_t` enum (EQ..AL, NV=4'b1111).
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `flags_t` typedef (logic [3:0]).
- Sub-module `cond_check`: purely combinational (`cond`, `flags`) → `pass`, `illegal`. `cond_unit` instantiates it once and adds the flag register and the M-stage registers.

## Test plan
- Reset, then an AL instruction with `flag_w_e`=11 and `alu_flags_e`=0100 → next cycle `flags_o`=0100. An EQ instruction then gives `cond_ex_e`=1 and `reg_write_m`=1 one cycle later.
- With flags=1000, instruction GE with `reg_write_e`=1 and `mem_write_e`=1 → `cond_ex_e`=0, both M outputs 0 next cycle, `flags_o` unchanged even with `flag_w_e`=11.
- With flags=0000, `flag_w_e`=10 and `alu_flags_e`=1111 → `flags_o`=1100, with C,V retained at 0.
- Every cond 0000..1110 against all 16 flag values, checked against the reference equations. Cond 1111 → `cond_ex_e`=0 and `cond_illegal_m`=1 next cycle.
- Stall and flush together while an AL flag-setting instruction is in E → `flags_o` holds and `valid_m`=0. Stall alone → all M outputs hold their previous values.
- Assert `rst_n`=0 mid-cycle while `valid_m`=1 and flags=1010 → outputs go to 0 immediately, without waiting for a clock edge.
